// File: rtl/etapa_fetch.sv
// etapa_fetch: instruction fetch stage for the monociclo_FPGA core.
// Keeps the PC, issues one single-cycle read per instruction to a variable
// latency instruction memory, and hands instruction/opcode/PC downstream
// through a valid/ready handshake. Taken branches redirect the next fetch.
//
// Optional build macro FETCH_HALT_EN: adds a HALT state entered when a
// SYSTEM instruction (ecall/ebreak) is accepted; only reset leaves it.
// Without the macro halted_o is tied low.
module etapa_fetch #(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_rvalid_i,
    input  logic [31:0]       imem_rdata_i,
    output logic [31:0]       instr_o,
    output logic [6:0]        opcode_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              valid_o,
    input  logic              ready_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              halted_o
);

    // Reset PC truncated to the address width, kept word aligned.
    localparam logic [ADDR_W-1:0] RESET_PC_A = RESET_PC[ADDR_W-1:0] & ~ADDR_W'(3);

    // Opcode shared by ecall/ebreak.
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_HALT
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] branch_pc;
    logic [ADDR_W-1:0] next_pc;
    logic              transfer;

    // Sequential and redirect address candidates; pc+4 wraps naturally.
    always_comb begin
        pc_plus4  = pc + ADDR_W'(4);
        branch_pc = branch_target_i & ~ADDR_W'(3);
        next_pc   = branch_i ? branch_pc : pc_plus4;
        transfer  = (state == S_HOLD) && ready_i;
    end

    // Single FSM: state, PC and every output register.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            pc          <= RESET_PC_A;
            instr_o     <= '0;
            opcode_o    <= '0;
            pc_o        <= '0;
            valid_o     <= 1'b0;
            imem_req_o  <= 1'b0;
            imem_addr_o <= '0;
`ifdef FETCH_HALT_EN
            halted_o    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    // Registered request: it is visible during the FETCH cycle.
                    state       <= S_FETCH;
                    imem_req_o  <= 1'b1;
                    imem_addr_o <= pc;
                end

                S_FETCH: begin
                    state       <= S_WAIT;
                    imem_req_o  <= 1'b0;
                    imem_addr_o <= '0;
                end

                S_WAIT: begin
                    // Responses are only honoured here, so stale ones are dropped.
                    if (imem_rvalid_i) begin
                        instr_o  <= imem_rdata_i;
                        opcode_o <= imem_rdata_i[6:0];
                        pc_o     <= pc;
                        valid_o  <= 1'b1;
                        state    <= S_HOLD;
                    end
                end

                S_HOLD: begin
                    if (transfer) begin
                        valid_o <= 1'b0;
`ifdef FETCH_HALT_EN
                        if (opcode_o == OPC_SYSTEM) begin
                            state    <= S_HALT;
                            halted_o <= 1'b1;
                        end else begin
                            pc          <= next_pc;
                            state       <= S_FETCH;
                            imem_req_o  <= 1'b1;
                            imem_addr_o <= next_pc;
                        end
`else
                        pc          <= next_pc;
                        state       <= S_FETCH;
                        imem_req_o  <= 1'b1;
                        imem_addr_o <= next_pc;
`endif
                    end
                end

                S_HALT: begin
                    // Terminal until reset.
                    state <= S_HALT;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifndef FETCH_HALT_EN
    assign halted_o = 1'b0;
`endif

endmodule

// File: tb/tb_etapa_fetch.sv
// Directed self-checking bench for etapa_fetch. Main instance uses the
// default RESET_PC; a second instance checks RESET_PC=32'hFFFF_FFFC wrap.
// Halt expectations follow FETCH_HALT_EN.
module tb_etapa_fetch;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o;
    logic [6:0]  opcode_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        ready_i;
    logic        branch_i;
    logic [31:0] branch_target_i;
    logic        halted_o;

    logic        rst2;
    logic        req2;
    logic [31:0] addr2;
    logic        rvalid2;
    logic [31:0] rdata2;
    logic [31:0] instr2;
    logic [6:0]  opcode2;
    logic [31:0] pc2;
    logic        valid2;
    logic        ready2;
    logic        halted2;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int req_seen  = 0;

    always #5 clk_i = ~clk_i;

    etapa_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .instr_o         (instr_o),
        .opcode_o        (opcode_o),
        .pc_o            (pc_o),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .halted_o        (halted_o)
    );

    etapa_fetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_hi (
        .clk_i           (clk_i),
        .rst_i           (rst2),
        .imem_req_o      (req2),
        .imem_addr_o     (addr2),
        .imem_rvalid_i   (rvalid2),
        .imem_rdata_i    (rdata2),
        .instr_o         (instr2),
        .opcode_o        (opcode2),
        .pc_o            (pc2),
        .valid_o         (valid2),
        .ready_i         (ready2),
        .branch_i        (1'b0),
        .branch_target_i (32'h0000_0000),
        .halted_o        (halted2)
    );

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        imem_rvalid_i = 1'b0;
        imem_rdata_i = '0;
        ready_i = 1'b0;
        branch_i = 1'b0;
        branch_target_i = '0;
        tick();
        rst_i = 1'b0;
    endtask

    // Called in the FETCH cycle; returns rvalid after lat cycles, ends in HOLD.
    task automatic respond(input int lat, input logic [31:0] data);
        tick();
        if (imem_req_o) req_seen++;
        for (int i = 1; i < lat; i++) begin
            tick();
            if (imem_req_o) req_seen++;
        end
        imem_rvalid_i = 1'b1;
        imem_rdata_i = data;
        tick();
        if (imem_req_o) req_seen++;
        imem_rvalid_i = 1'b0;
        imem_rdata_i = '0;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h0) $display("FAIL reset_req: req=%0b addr=%h exp 0/0", imem_req_o, imem_addr_o);
        else pass_cnt++;
        total_cnt++;
        if (valid_o !== 1'b0 || halted_o !== 1'b0) $display("FAIL reset_flags: valid=%0b halted=%0b exp 0/0", valid_o, halted_o);
        else pass_cnt++;
        total_cnt++;
        if (instr_o !== 32'h0 || opcode_o !== 7'h0 || pc_o !== 32'h0) $display("FAIL reset_data: instr=%h op=%h pc=%h exp 0", instr_o, opcode_o, pc_o);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) $display("FAIL first_req: req=%0b addr=%h exp 1/0", imem_req_o, imem_addr_o);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        ready_i = 1'b1;
        respond(1, 32'h0050_0093);
        total_cnt++;
        if (valid_o !== 1'b1 || opcode_o !== 7'b0010011 || pc_o !== 32'h0 || instr_o !== 32'h0050_0093)
            $display("FAIL basic_capture: valid=%0b op=%b pc=%h instr=%h exp 1/0010011/0/00500093", valid_o, opcode_o, pc_o, instr_o);
        else pass_cnt++;
        tick();
        ready_i = 1'b0;
        total_cnt++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4 || valid_o !== 1'b0)
            $display("FAIL basic_next: req=%0b addr=%h valid=%0b exp 1/4/0", imem_req_o, imem_addr_o, valid_o);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        req_seen = 1;
        ready_i = 1'b0;
        respond(4, 32'h00A0_0113);
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if (valid_o !== 1'b1 || instr_o !== 32'h00A0_0113 || opcode_o !== 7'h13 || pc_o !== 32'h4 || imem_req_o !== 1'b0)
                $display("FAIL stall_hold%0d: valid=%0b instr=%h pc=%h req=%0b exp 1/00a00113/4/0", i, valid_o, instr_o, pc_o, imem_req_o);
            else pass_cnt++;
            tick();
            if (imem_req_o) req_seen++;
        end
        total_cnt++;
        if (req_seen !== 1) $display("FAIL stall_pulses: req pulses=%0d exp 1", req_seen);
        else pass_cnt++;
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        total_cnt++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) $display("FAIL stall_next: req=%0b addr=%h exp 1/8", imem_req_o, imem_addr_o);
        else pass_cnt++;
    endtask

    task automatic test_branch();
        respond(1, 32'h0000_0063);
        branch_i = 1'b1;
        branch_target_i = 32'h0000_0100;
        tick();
        total_cnt++;
        if (valid_o !== 1'b1 || imem_req_o !== 1'b0) $display("FAIL branch_noready: valid=%0b req=%0b exp 1/0", valid_o, imem_req_o);
        else pass_cnt++;
        branch_target_i = 32'h0000_0043;
        ready_i = 1'b1;
        tick();
        branch_i = 1'b0;
        branch_target_i = '0;
        ready_i = 1'b0;
        total_cnt++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h40) $display("FAIL branch_taken: req=%0b addr=%h exp 1/40", imem_req_o, imem_addr_o);
        else pass_cnt++;
        respond(1, 32'h0000_0013);
        total_cnt++;
        if (pc_o !== 32'h40) $display("FAIL branch_pc: pc=%h exp 40", pc_o);
        else pass_cnt++;
        branch_i = 1'b1;
        branch_target_i = 32'h0000_0200;
        tick();
        branch_i = 1'b0;
        branch_target_i = '0;
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        total_cnt++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h44) $display("FAIL branch_ignored: req=%0b addr=%h exp 1/44", imem_req_o, imem_addr_o);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        respond(1, 32'h0000_0013);
        ready_i = 1'b1;
        branch_i = 1'b1;
        branch_target_i = 32'hFFFF_FFFF;
        tick();
        ready_i = 1'b0;
        branch_i = 1'b0;
        branch_target_i = '0;
        total_cnt++;
        if (imem_addr_o !== 32'hFFFF_FFFC) $display("FAIL wrap_align: addr=%h exp fffffffc", imem_addr_o);
        else pass_cnt++;
        respond(2, 32'h0000_0013);
        total_cnt++;
        if (pc_o !== 32'hFFFF_FFFC) $display("FAIL wrap_pc: pc=%h exp fffffffc", pc_o);
        else pass_cnt++;
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        total_cnt++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) $display("FAIL wrap_next: req=%0b addr=%h exp 1/0", imem_req_o, imem_addr_o);
        else pass_cnt++;
    endtask

    task automatic test_reset_in_wait();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        total_cnt++;
        if (valid_o !== 1'b0 || imem_req_o !== 1'b0) $display("FAIL rst_wait_idle: valid=%0b req=%0b exp 0/0", valid_o, imem_req_o);
        else pass_cnt++;
        imem_rvalid_i = 1'b1;
        imem_rdata_i = 32'hDEAD_BEEF;
        tick();
        imem_rvalid_i = 1'b0;
        imem_rdata_i = '0;
        total_cnt++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || valid_o !== 1'b0)
            $display("FAIL rst_wait_req: req=%0b addr=%h valid=%0b exp 1/0/0", imem_req_o, imem_addr_o, valid_o);
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (valid_o !== 1'b0 || instr_o !== 32'h0) $display("FAIL rst_wait_drop: valid=%0b instr=%h exp 0/0", valid_o, instr_o);
        else pass_cnt++;
    endtask

    task automatic test_halt();
        do_reset();
        tick();
        respond(1, 32'h0010_0073);
        total_cnt++;
        if (opcode_o !== 7'b1110011) $display("FAIL halt_opcode: op=%b exp 1110011", opcode_o);
        else pass_cnt++;
        ready_i = 1'b1;
        tick();
`ifdef FETCH_HALT_EN
        total_cnt++;
        if (halted_o !== 1'b1 || valid_o !== 1'b0 || imem_req_o !== 1'b0)
            $display("FAIL halt_enter: halted=%0b valid=%0b req=%0b exp 1/0/0", halted_o, valid_o, imem_req_o);
        else pass_cnt++;
        req_seen = 0;
        for (int i = 0; i < 8; i++) begin
            imem_rvalid_i = i[0];
            tick();
            if (imem_req_o) req_seen++;
        end
        imem_rvalid_i = 1'b0;
        total_cnt++;
        if (req_seen !== 0 || halted_o !== 1'b1) $display("FAIL halt_stay: req pulses=%0d halted=%0b exp 0/1", req_seen, halted_o);
        else pass_cnt++;
        do_reset();
        total_cnt++;
        if (halted_o !== 1'b0) $display("FAIL halt_reset: halted=%0b exp 0", halted_o);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) $display("FAIL halt_restart: req=%0b addr=%h exp 1/0", imem_req_o, imem_addr_o);
        else pass_cnt++;
`else
        ready_i = 1'b0;
        total_cnt++;
        if (halted_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h4)
            $display("FAIL system_plain: halted=%0b req=%0b addr=%h exp 0/1/4", halted_o, imem_req_o, imem_addr_o);
        else pass_cnt++;
`endif
        ready_i = 1'b0;
    endtask

    task automatic test_reset_pc();
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        tick();
        total_cnt++;
        if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) $display("FAIL rpc_first: req=%0b addr=%h exp 1/fffffffc", req2, addr2);
        else pass_cnt++;
        tick();
        rvalid2 = 1'b1;
        rdata2 = 32'h0000_0013;
        tick();
        rvalid2 = 1'b0;
        total_cnt++;
        if (valid2 !== 1'b1 || pc2 !== 32'hFFFF_FFFC || halted2 !== 1'b0) $display("FAIL rpc_capture: valid=%0b pc=%h exp 1/fffffffc", valid2, pc2);
        else pass_cnt++;
        ready2 = 1'b1;
        tick();
        ready2 = 1'b0;
        total_cnt++;
        if (req2 !== 1'b1 || addr2 !== 32'h0) $display("FAIL rpc_wrap: req=%0b addr=%h exp 1/0", req2, addr2);
        else pass_cnt++;
    endtask

    initial begin
        rst2 = 1'b1;
        rvalid2 = 1'b0;
        rdata2 = '0;
        ready2 = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_branch();
        test_wrap();
        test_reset_in_wait();
        test_halt();
        test_reset_pc();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/etapa_fetch.md
Name: etapa_fetch

Overview:
- Instruction fetch stage for the monociclo_FPGA core; upstream producer of the opcode consumed by the control decoder.
- Holds the PC, requests instruction words from instruction memory (variable latency ≥1 cycle), and presents instruction, opcode and PC downstream under a valid/ready handshake.
- Accepts branch redirects from the execute stage.

Parameters:
- ADDR_W, 32, width of PC and instruction-memory address.
- RESET_PC, 32'h0000_0000, PC value loaded on reset (truncated to ADDR_W, bits [1:0] must be 0).

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; synchronous, active-high.
- imem_req_o  output  1  read request, one-cycle pulse per fetch.
- imem_addr_o  output  ADDR_W  byte address of request, valid while imem_req_o=1, else 0.
- imem_rvalid_i  input  1  read data valid.
- imem_rdata_i  input  32  instruction word.
- instr_o  output  32  registered instruction.
- opcode_o  output  7  registered instr_o[6:0], drives decoder opcode_i.
- pc_o  output  ADDR_W  address of instr_o.
- valid_o  output  1  instr_o/opcode_o/pc_o valid.
- ready_i  input  1  downstream accepts the current instruction.
- branch_i  input  1  branch taken for the instruction being accepted.
- branch_target_i  input  ADDR_W  branch destination.
- halted_o  output  1  fetch stopped (see Optional Feature).

Behaviour:
- Reset (rst_i=1 at rising edge): state=IDLE, pc=RESET_PC, instr_o=0, opcode_o=0 (decoder default, all controls 0), pc_o=0, valid_o=0, imem_req_o=0, imem_addr_o=0, halted_o=0. Reset has priority over all other inputs in any state, including WAIT with a request outstanding.
- IDLE: one cycle, then go to FETCH.
- FETCH: imem_req_o=1, imem_addr_o=pc for exactly this cycle, then go to WAIT.
- WAIT: on imem_rvalid_i=1, capture instr_o=imem_rdata_i, opcode_o=imem_rdata_i[6:0], pc_o=pc, set valid_o=1, go to HOLD. Otherwise stay in WAIT.
- imem_rvalid_i is ignored in every state except WAIT, so stale responses after a reset are dropped.
- HOLD: valid_o=1 and outputs stable while ready_i=0. On ready_i=1 (transfer), clear valid_o and go to FETCH.
  - Next pc = {branch_target_i[ADDR_W-1:2],2'b00} if branch_i=1, else pc+4.
  - branch_i and branch_target_i are sampled only on the transfer cycle and ignored otherwise.
- Arithmetic: pc+4 wraps modulo 2^ADDR_W (e.g. 32'hFFFF_FFFC -> 32'h0000_0000). Branch target bits [1:0] are silently cleared; no error is flagged.
- Latency: the request is issued 2 cycles after reset deasserts. valid_o rises the cycle after imem_rvalid_i. Best-case throughput is one instruction per 3 cycles (FETCH, WAIT, HOLD with ready_i=1).
- Simultaneous events:
  - rvalid arriving in the same cycle as the request is not legal for memory; minimum latency is 1 cycle.
  - branch_i with ready_i=0 has no effect.
- Without the optional feature, halted_o is constantly 0.

Optional Feature:
- Macro FETCH_HALT_EN.
- Defined: adds a HALT state. When a transfer occurs in HOLD with opcode_o=7'b1110011 (SYSTEM: ecall/ebreak), go to HALT instead of FETCH.
  - In HALT: halted_o=1, imem_req_o=0, valid_o=0. branch_i is ignored for this transfer.
  - HALT is left only by rst_i.
- Not defined: no HALT state; SYSTEM instructions are treated like any other (pc+4); halted_o tied 0.

Test Plan:
- Reset, then memory returns 32'h00500093 with 1-cycle latency and ready_i=1 -> imem_addr_o=0 in cycle 2; valid_o=1 with opcode_o=7'b0010011 and pc_o=0; next request addr=4.
- Memory latency 4 cycles, ready_i held 0 for 5 cycles in HOLD -> imem_req_o pulses once, outputs stable throughout, no new request until ready_i=1.
- Transfer with branch_i=1 and branch_target_i=32'h0000_0043 -> next imem_addr_o=32'h0000_0040. branch_i=1 with ready_i=0 -> ignored, next addr=pc+4.
- RESET_PC=32'hFFFF_FFFC, accept one instruction -> next imem_addr_o=32'h0000_0000.
- Assert rst_i while in WAIT, then pulse imem_rvalid_i during IDLE -> response dropped; valid_o=0; new request at RESET_PC.
- With FETCH_HALT_EN, fetch 32'h00100073 (ebreak) and accept it -> halted_o=1, no further imem_req_o until rst_i. Without the macro -> next addr=pc+4, halted_o=0.
